// File: rtl/pulse_gen_pkg.sv
// Shared types and helpers for the multi-channel pulse generator.
// Holds the channel state encoding, bus-slicing helpers and default field widths.
package pulse_gen_pkg;

  localparam int unsigned DefChNum      = 4;
  localparam int unsigned DefClkFreqMhz = 125;
  localparam int unsigned DefWidthW     = 11;
  localparam int unsigned DefNumW       = 11;
  localparam int unsigned DefGapW       = 16;
  localparam int unsigned DefDelayW     = 16;

  typedef enum logic [2:0] {
    ChIdle,
    ChDelay,
    ChHigh,
    ChGap,
    ChDone
  } ch_state_e;

  // LSB of channel ch's field inside a packed per-channel bus.
  function automatic int unsigned field_lsb(input int unsigned ch, input int unsigned field_w);
    return ch * field_w;
  endfunction

  function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Prescaler width; a 1 MHz clock still needs a 1-bit register.
  function automatic int unsigned prescale_w(input int unsigned freq);
    return (freq > 1) ? $clog2(freq) : 1;
  endfunction

endpackage

// File: rtl/pulse_gen_ch.sv
// One pulse-train channel: delay, high/gap sequencing and microsecond gap prescaler.
// Config inputs must stay stable for the whole burst; the top level guarantees that.
module pulse_gen_ch
  import pulse_gen_pkg::*;
#(
  parameter int unsigned CLK_FREQ_MHZ = DefClkFreqMhz,
  parameter int unsigned WIDTH_W      = DefWidthW,
  parameter int unsigned NUM_W        = DefNumW,
  parameter int unsigned GAP_W        = DefGapW,
  parameter int unsigned DELAY_W      = DefDelayW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               launch_i,
  input  logic               abort_i,
  input  logic               en_i,
  input  logic [WIDTH_W-1:0] width_i,
  input  logic [NUM_W-1:0]   num_i,
  input  logic [GAP_W-1:0]   gap_i,
  input  logic [DELAY_W-1:0] delay_i,
  output logic               q_o,
  output logic               done_o
);

  localparam int unsigned CntW = max_w(WIDTH_W, DELAY_W);
  localparam int unsigned PreW = prescale_w(CLK_FREQ_MHZ);
  localparam logic [PreW-1:0] PreLast = PreW'(CLK_FREQ_MHZ - 1);

  ch_state_e         state_q;
  logic [CntW-1:0]   cnt_q;
  logic [NUM_W-1:0]  pulse_q;
  logic [PreW-1:0]   pre_q;
  logic [GAP_W-1:0]  us_q;
  logic              q_q;
  logic              pulse_ok;
  logic              gap_end;

  always_comb begin
    pulse_ok = (width_i != '0) && (num_i != '0);
    // A zero gap still yields one low cycle, so it ends on the first GAP cycle.
    gap_end  = (gap_i == '0) || ((pre_q == PreLast) && (us_q == gap_i - GAP_W'(1)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ChIdle;
      cnt_q   <= '0;
      pulse_q <= '0;
      pre_q   <= '0;
      us_q    <= '0;
      q_q     <= 1'b0;
    end else if (abort_i) begin
      state_q <= ChIdle;
      q_q     <= 1'b0;
    end else if (launch_i) begin
      pulse_q <= '0;
      if (!en_i) begin
        state_q <= ChDone;
        q_q     <= 1'b0;
      end else if (delay_i != '0) begin
        state_q <= ChDelay;
        cnt_q   <= CntW'(delay_i);
        q_q     <= 1'b0;
      end else if (pulse_ok) begin
        state_q <= ChHigh;
        cnt_q   <= CntW'(width_i);
        q_q     <= 1'b1;
      end else begin
        state_q <= ChDone;
        q_q     <= 1'b0;
      end
    end else begin
      unique case (state_q)
        ChDelay: begin
          if (cnt_q == CntW'(1)) begin
            if (pulse_ok) begin
              state_q <= ChHigh;
              cnt_q   <= CntW'(width_i);
              q_q     <= 1'b1;
            end else begin
              state_q <= ChDone;
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        ChHigh: begin
          if (cnt_q == CntW'(1)) begin
            q_q <= 1'b0;
            if (pulse_q == num_i - NUM_W'(1)) begin
              state_q <= ChDone;
            end else begin
              state_q <= ChGap;
              pulse_q <= pulse_q + NUM_W'(1);
              pre_q   <= '0;
              us_q    <= '0;
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        ChGap: begin
          if (gap_end) begin
            state_q <= ChHigh;
            cnt_q   <= CntW'(width_i);
            q_q     <= 1'b1;
          end else if (pre_q == PreLast) begin
            pre_q <= '0;
            us_q  <= us_q + GAP_W'(1);
          end else begin
            pre_q <= pre_q + PreW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign q_o    = q_q;
  assign done_o = (state_q == ChDone);

endmodule

// File: rtl/pulse_gen_multi.sv
// Multi-channel pulse generator: start edge detect, config latch, burst control
// (single/continuous/abort) and the shared trig/done/busy strobes.
module pulse_gen_multi
  import pulse_gen_pkg::*;
#(
  parameter int unsigned CH_NUM       = DefChNum,
  parameter int unsigned CLK_FREQ_MHZ = DefClkFreqMhz,
  parameter int unsigned WIDTH_W      = DefWidthW,
  parameter int unsigned NUM_W        = DefNumW,
  parameter int unsigned GAP_W        = DefGapW,
  parameter int unsigned DELAY_W      = DefDelayW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      stop_i,
  input  logic                      mode_i,
  input  logic [CH_NUM-1:0]         ch_en_i,
  input  logic [CH_NUM*WIDTH_W-1:0] pulse_width_i,
  input  logic [CH_NUM*NUM_W-1:0]   pulse_num_i,
  input  logic [CH_NUM*GAP_W-1:0]   gap_us_i,
  input  logic [CH_NUM*DELAY_W-1:0] delay_i,
  output logic [CH_NUM-1:0]         q_o,
  output logic                      trig_o,
  output logic                      done_o,
  output logic                      busy_o
);

  logic                      start_q;
  logic                      busy_q;
  logic                      trig_q;
  logic                      done_q;
  logic [CH_NUM-1:0]         en_q;
  logic [CH_NUM*WIDTH_W-1:0] width_q;
  logic [CH_NUM*NUM_W-1:0]   num_q;
  logic [CH_NUM*GAP_W-1:0]   gap_q;
  logic [CH_NUM*DELAY_W-1:0] delay_q;

  logic                      start_evt;
  logic                      complete;
  logic                      launch;
  logic [CH_NUM-1:0]         ch_done;
  logic [CH_NUM-1:0]         en_cfg;
  logic [CH_NUM*WIDTH_W-1:0] width_cfg;
  logic [CH_NUM*NUM_W-1:0]   num_cfg;
  logic [CH_NUM*GAP_W-1:0]   gap_cfg;
  logic [CH_NUM*DELAY_W-1:0] delay_cfg;

  always_comb begin
    start_evt = start_i & ~start_q & ~busy_q & ~stop_i & (|ch_en_i);
    complete  = busy_q & (&ch_done) & ~stop_i;
    launch    = start_evt | (complete & mode_i);
    // Channels launch on the same edge as the latch, so they see the live inputs then.
    en_cfg    = start_evt ? ch_en_i       : en_q;
    width_cfg = start_evt ? pulse_width_i : width_q;
    num_cfg   = start_evt ? pulse_num_i   : num_q;
    gap_cfg   = start_evt ? gap_us_i      : gap_q;
    delay_cfg = start_evt ? delay_i       : delay_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      trig_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= '0;
      width_q <= '0;
      num_q   <= '0;
      gap_q   <= '0;
      delay_q <= '0;
    end else begin
      start_q <= start_i;
      trig_q  <= 1'b0;
      done_q  <= 1'b0;
      if (stop_i) begin
        busy_q <= 1'b0;
      end else if (start_evt) begin
        busy_q  <= 1'b1;
        trig_q  <= 1'b1;
        en_q    <= ch_en_i;
        width_q <= pulse_width_i;
        num_q   <= pulse_num_i;
        gap_q   <= gap_us_i;
        delay_q <= delay_i;
      end else if (complete) begin
        done_q <= 1'b1;
        if (mode_i) begin
          trig_q <= 1'b1;
        end else begin
          busy_q <= 1'b0;
        end
      end
    end
  end

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    pulse_gen_ch #(
      .CLK_FREQ_MHZ(CLK_FREQ_MHZ),
      .WIDTH_W     (WIDTH_W),
      .NUM_W       (NUM_W),
      .GAP_W       (GAP_W),
      .DELAY_W     (DELAY_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .launch_i(launch),
      .abort_i (stop_i),
      .en_i    (en_cfg[c]),
      .width_i (width_cfg[field_lsb(c, WIDTH_W) +: WIDTH_W]),
      .num_i   (num_cfg[field_lsb(c, NUM_W) +: NUM_W]),
      .gap_i   (gap_cfg[field_lsb(c, GAP_W) +: GAP_W]),
      .delay_i (delay_cfg[field_lsb(c, DELAY_W) +: DELAY_W]),
      .q_o     (q_o[c]),
      .done_o  (ch_done[c])
    );
  end

  assign trig_o = trig_q;
  assign done_o = done_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Bench for pulse_gen_multi: directed and random bursts checked cycle by cycle against
// a closed-form model of each channel's pulse train.
module tb_pulse_gen_multi;

  localparam int unsigned CH_NUM       = 4;
  localparam int unsigned CLK_FREQ_MHZ = 125;
  localparam int unsigned WIDTH_W      = 11;
  localparam int unsigned NUM_W        = 11;
  localparam int unsigned GAP_W        = 16;
  localparam int unsigned DELAY_W      = 16;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      start_i;
  logic                      stop_i;
  logic                      mode_i;
  logic [CH_NUM-1:0]         ch_en_i;
  logic [CH_NUM*WIDTH_W-1:0] pulse_width_i;
  logic [CH_NUM*NUM_W-1:0]   pulse_num_i;
  logic [CH_NUM*GAP_W-1:0]   gap_us_i;
  logic [CH_NUM*DELAY_W-1:0] delay_i;
  logic [CH_NUM-1:0]         q_o;
  logic                      trig_o;
  logic                      done_o;
  logic                      busy_o;

  logic [WIDTH_W-1:0] cfg_w [CH_NUM];
  logic [NUM_W-1:0]   cfg_n [CH_NUM];
  logic [GAP_W-1:0]   cfg_g [CH_NUM];
  logic [DELAY_W-1:0] cfg_d [CH_NUM];

  for (genvar c = 0; c < CH_NUM; c++) begin : g_pack
    assign pulse_width_i[c*WIDTH_W +: WIDTH_W] = cfg_w[c];
    assign pulse_num_i[c*NUM_W +: NUM_W]       = cfg_n[c];
    assign gap_us_i[c*GAP_W +: GAP_W]          = cfg_g[c];
    assign delay_i[c*DELAY_W +: DELAY_W]       = cfg_d[c];
  end

  pulse_gen_multi #(
    .CH_NUM      (CH_NUM),
    .CLK_FREQ_MHZ(CLK_FREQ_MHZ),
    .WIDTH_W     (WIDTH_W),
    .NUM_W       (NUM_W),
    .GAP_W       (GAP_W),
    .DELAY_W     (DELAY_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .stop_i       (stop_i),
    .mode_i       (mode_i),
    .ch_en_i      (ch_en_i),
    .pulse_width_i(pulse_width_i),
    .pulse_num_i  (pulse_num_i),
    .gap_us_i     (gap_us_i),
    .delay_i      (delay_i),
    .q_o          (q_o),
    .trig_o       (trig_o),
    .done_o       (done_o),
    .busy_o       (busy_o)
  );

  always #4 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model state: burst launch cycle, expected done cycle and latched configuration.
  bit busy_m     = 1'b0;
  bit active     = 1'b0;
  bit prev_start = 1'b0;
  int launch_c   = 0;
  int done_c     = 0;
  bit m_en [CH_NUM];
  int m_w  [CH_NUM];
  int m_n  [CH_NUM];
  int m_g  [CH_NUM];
  int m_d  [CH_NUM];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic int low_cycles(input int g);
    return (g == 0) ? 1 : g * CLK_FREQ_MHZ;
  endfunction

  // Cycle (relative to launch) on which the channel's last output transition lands.
  function automatic int rel_fin(input int c);
    if (!m_en[c]) return 0;
    if (m_w[c] == 0 || m_n[c] == 0) return m_d[c];
    return m_d[c] + m_n[c] * m_w[c] + (m_n[c] - 1) * low_cycles(m_g[c]);
  endfunction

  function automatic int max_fin();
    int m = 0;
    for (int c = 0; c < CH_NUM; c++) if (rel_fin(c) > m) m = rel_fin(c);
    return m;
  endfunction

  function automatic logic exp_q(input int c, input int r);
    int k;
    int per;
    if (!active || !m_en[c] || m_w[c] == 0 || m_n[c] == 0 || r < m_d[c]) return 1'b0;
    k   = r - m_d[c];
    per = m_w[c] + low_cycles(m_g[c]);
    return ((k / per) < m_n[c]) && ((k % per) < m_w[c]);
  endfunction

  task automatic set_ch(input int c, input bit en, input int w, input int n, input int g,
                        input int d);
    ch_en_i[c] = en;
    cfg_w[c]   = WIDTH_W'(w);
    cfg_n[c]   = NUM_W'(n);
    cfg_g[c]   = GAP_W'(g);
    cfg_d[c]   = DELAY_W'(d);
  endtask

  task automatic step(input int ncyc, input string tag);
    for (int i = 0; i < ncyc; i++) begin
      bit sevt;
      bit start_now;
      bit stop_now;
      bit mode_now;
      bit trig_m;
      bit done_m;
      logic [CH_NUM-1:0] q_m;
      start_now = start_i;
      stop_now  = stop_i;
      mode_now  = mode_i;
      sevt      = start_now && !prev_start && !busy_m && !stop_now && (ch_en_i != '0);
      @(posedge clk);
      cyc++;
      prev_start = start_now;
      trig_m = 1'b0;
      done_m = 1'b0;
      if (stop_now) begin
        busy_m = 1'b0;
        active = 1'b0;
      end else if (sevt) begin
        for (int c = 0; c < CH_NUM; c++) begin
          m_en[c] = ch_en_i[c];
          m_w[c]  = int'(cfg_w[c]);
          m_n[c]  = int'(cfg_n[c]);
          m_g[c]  = int'(cfg_g[c]);
          m_d[c]  = int'(cfg_d[c]);
        end
        busy_m   = 1'b1;
        active   = 1'b1;
        trig_m   = 1'b1;
        launch_c = cyc;
        done_c   = cyc + max_fin() + 1;
      end else if (busy_m && cyc == done_c) begin
        done_m = 1'b1;
        if (mode_now) begin
          trig_m   = 1'b1;
          launch_c = cyc;
          done_c   = cyc + max_fin() + 1;
        end else begin
          busy_m = 1'b0;
        end
      end
      for (int c = 0; c < CH_NUM; c++) q_m[c] = exp_q(c, cyc - launch_c);
      #1;
      check(tag, 32'({busy_o, done_o, trig_o, q_o}), 32'({busy_m, done_m, trig_m, q_m}));
    end
  endtask

  task automatic burst(input string tag);
    start_i = 1'b1;
    step(1, tag);
    start_i = 1'b0;
    step(done_c - cyc + 2, tag);
  endtask

  task automatic reset_mid(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check(tag, 32'({busy_o, done_o, trig_o, q_o}), 32'd0);
    busy_m     = 1'b0;
    active     = 1'b0;
    prev_start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    start_i = 1'b0;
    stop_i  = 1'b0;
    mode_i  = 1'b0;
    for (int c = 0; c < CH_NUM; c++) set_ch(c, 1'b0, 0, 0, 0, 0);
    #20;
    check("reset", 32'({busy_o, done_o, trig_o, q_o}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(2, "idle");

    // Single channel, three 10-cycle pulses with 2 us gaps.
    set_ch(0, 1'b1, 10, 3, 2, 0);
    burst("basic");

    // Staggered delays and differing pulse counts.
    set_ch(0, 1'b1, 4, 1, 0, 0);
    set_ch(1, 1'b1, 6, 2, 1, 5);
    set_ch(2, 1'b1, 8, 3, 0, 100);
    set_ch(3, 1'b1, 5, 2, 2, 1000);
    burst("delays");

    // Partial enable, zero-width channels.
    set_ch(0, 1'b1, 5, 2, 0, 0);
    set_ch(1, 1'b0, 0, 3, 0, 0);
    set_ch(2, 1'b1, 0, 2, 0, 9);
    set_ch(3, 1'b0, 7, 2, 0, 0);
    burst("enables");

    // No channel enabled: start is ignored.
    for (int c = 0; c < CH_NUM; c++) set_ch(c, 1'b0, 5, 1, 0, 0);
    start_i = 1'b1;
    step(1, "no_en");
    start_i = 1'b0;
    step(4, "no_en");

    // Maximum pulse width.
    set_ch(3, 1'b1, (1 << WIDTH_W) - 1, 1, 0, 0);
    burst("max_width");

    // Continuous mode, start pulses while busy, then mode cleared mid third burst.
    set_ch(0, 1'b1, 3, 2, 0, 0);
    set_ch(1, 1'b1, 2, 1, 0, 7);
    set_ch(2, 1'b0, 0, 0, 0, 0);
    set_ch(3, 1'b0, 0, 0, 0, 0);
    mode_i  = 1'b1;
    start_i = 1'b1;
    step(1, "cont");
    start_i = 1'b0;
    step(done_c - cyc, "cont");
    start_i = 1'b1;
    step(1, "cont_busy_start");
    start_i = 1'b0;
    step(1, "cont_busy_start");
    step(done_c - cyc, "cont");
    mode_i = 1'b0;
    step(done_c - cyc + 3, "cont_end");

    // Abort in the middle of a high phase.
    set_ch(0, 1'b1, 20, 2, 1, 3);
    set_ch(1, 1'b0, 0, 0, 0, 0);
    start_i = 1'b1;
    step(1, "stop_high");
    start_i = 1'b0;
    step(8, "stop_high");
    stop_i = 1'b1;
    step(1, "stop_high");
    stop_i = 1'b0;
    step(5, "stop_high");

    // Abort on the completion edge in continuous mode: no done, no restart.
    set_ch(0, 1'b1, 3, 2, 0, 0);
    set_ch(1, 1'b1, 2, 1, 0, 7);
    mode_i  = 1'b1;
    start_i = 1'b1;
    step(1, "stop_done");
    start_i = 1'b0;
    step(done_c - cyc - 1, "stop_done");
    stop_i = 1'b1;
    step(1, "stop_done");
    stop_i = 1'b0;
    mode_i = 1'b0;
    step(5, "stop_done");

    // Asynchronous reset in a gap, then a fresh burst with new inputs.
    set_ch(0, 1'b1, 10, 3, 2, 0);
    set_ch(1, 1'b0, 0, 0, 0, 0);
    start_i = 1'b1;
    step(1, "rst_gap");
    start_i = 1'b0;
    step(30, "rst_gap");
    reset_mid("rst_async");
    set_ch(0, 1'b1, 6, 2, 0, 2);
    set_ch(1, 1'b1, 3, 1, 0, 0);
    burst("after_rst");

    // Randomised single bursts.
    for (int t = 0; t < 8; t++) begin
      for (int c = 0; c < CH_NUM; c++) begin
        set_ch(c, 1'($urandom_range(0, 1)), int'($urandom_range(0, 12)),
               int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 40)));
      end
      if (ch_en_i == '0) ch_en_i[0] = 1'b1;
      burst("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
